// File: rtl/result_display.sv
`default_nettype none
// ---------------------------------------------------------------------------
// result_display: signed adder result -> BCD -> multiplexed 3-digit 7-seg
// Revision: 1.0
// ---------------------------------------------------------------------------
module result_display #(
  parameter int REFRESH_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_sub,
  input  logic       in_ca,
  input  logic [3:0] in_s,
  output logic       out_ready,
  output logic       out_done,
  output logic [6:0] out_seg,
  output logic [2:0] out_an
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CONV = 1'b1;

  localparam int                c_CW      = $clog2(REFRESH_DIV);
  localparam logic [c_CW-1:0]   c_CNT_MAX = c_CW'(REFRESH_DIV - 1);
  localparam logic [1:0]        c_SEL_UNITS = 2'd0;
  localparam logic [1:0]        c_SEL_TENS  = 2'd1;
  localparam logic [1:0]        c_SEL_SIGN  = 2'd2;
  localparam logic [6:0]        c_SEG_MINUS = 7'b0111111;
  localparam logic [6:0]        c_SEG_BLANK = 7'b1111111;

  logic [0:0]      r_state;
  logic [2:0]      r_step;
  logic [4:0]      r_bin;
  logic [3:0]      r_bcd_u;
  logic            r_bcd_t;
  logic            r_neg_pend;
  logic [3:0]      r_units;
  logic [1:0]      r_tens;
  logic            r_neg;
  logic            r_done;
  logic [c_CW-1:0] r_cnt;
  logic [1:0]      r_sel;
  logic [6:0]      r_seg;
  logic [2:0]      r_an;

  logic            w_accept;
  logic            w_last;
  logic [4:0]      w_mag;
  logic            w_neg;
  logic [3:0]      w_u_adj;
  logic [3:0]      w_u_shift;
  logic [1:0]      w_t_shift;
  logic [3:0]      w_units_nxt;
  logic [1:0]      w_tens_nxt;
  logic            w_neg_nxt;
  logic            w_wrap;
  logic [1:0]      w_sel_nxt;
  logic [6:0]      w_seg_nxt;
  logic [2:0]      w_an_nxt;

  function automatic logic [6:0] f_digit(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_last   = (r_state == S_CONV) && (r_step == 3'd4);

  // Subtract without carry-out means a borrow: the sum is the two's complement of the magnitude.
  always_comb begin
    w_mag = {in_ca, in_s};
    w_neg = 1'b0;
    if (in_sub) begin
      if (in_ca) begin
        w_mag = {1'b0, in_s};
      end else begin
        w_mag = 5'd16 - {1'b0, in_s};
        w_neg = 1'b1;
      end
    end
  end

  // Tens never exceeds 1 before the final shift, so only units needs the add-3 correction.
  assign w_u_adj   = (r_bcd_u >= 4'd5) ? (r_bcd_u + 4'd3) : r_bcd_u;
  assign w_u_shift = {w_u_adj[2:0], r_bin[4]};
  assign w_t_shift = {r_bcd_t, w_u_adj[3]};

  assign w_units_nxt = w_last ? w_u_shift  : r_units;
  assign w_tens_nxt  = w_last ? w_t_shift  : r_tens;
  assign w_neg_nxt   = w_last ? r_neg_pend : r_neg;

  assign w_wrap    = (r_cnt == c_CNT_MAX);
  assign w_sel_nxt = !w_wrap ? r_sel :
                     (r_sel == c_SEL_UNITS) ? c_SEL_TENS :
                     (r_sel == c_SEL_TENS)  ? c_SEL_SIGN : c_SEL_UNITS;

  // Decode from next-cycle values so new digits appear on the same edge they are latched.
  always_comb begin
    w_seg_nxt = f_digit(w_units_nxt);
    w_an_nxt  = 3'b110;
    case (w_sel_nxt)
      c_SEL_TENS: begin
        w_seg_nxt = (w_tens_nxt == 2'd0) ? c_SEG_BLANK : f_digit({2'b00, w_tens_nxt});
        w_an_nxt  = 3'b101;
      end
      c_SEL_SIGN: begin
        w_seg_nxt = w_neg_nxt ? c_SEG_MINUS : c_SEG_BLANK;
        w_an_nxt  = 3'b011;
      end
      default: begin
        w_seg_nxt = f_digit(w_units_nxt);
        w_an_nxt  = 3'b110;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_step     <= 3'd0;
      r_bin      <= 5'd0;
      r_bcd_u    <= 4'd0;
      r_bcd_t    <= 1'b0;
      r_neg_pend <= 1'b0;
      r_units    <= 4'd0;
      r_tens     <= 2'd0;
      r_neg      <= 1'b0;
      r_done     <= 1'b0;
      r_cnt      <= '0;
      r_sel      <= c_SEL_UNITS;
      r_seg      <= 7'b1000000;
      r_an       <= 3'b110;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state    <= S_CONV;
            r_step     <= 3'd0;
            r_bin      <= w_mag;
            r_neg_pend <= w_neg;
            r_bcd_u    <= 4'd0;
            r_bcd_t    <= 1'b0;
          end
        end
        default: begin
          r_step  <= r_step + 3'd1;
          r_bin   <= {r_bin[3:0], 1'b0};
          r_bcd_u <= w_u_shift;
          r_bcd_t <= w_t_shift[0];
          if (w_last) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
      endcase
      r_units <= w_units_nxt;
      r_tens  <= w_tens_nxt;
      r_neg   <= w_neg_nxt;
      r_cnt   <= w_wrap ? '0 : (r_cnt + 1'b1);
      r_sel   <= w_sel_nxt;
      r_seg   <= w_seg_nxt;
      r_an    <= w_an_nxt;
    end
  end

  assign out_ready = (r_state == S_IDLE);
  assign out_done  = r_done;
  assign out_seg   = r_seg;
  assign out_an    = r_an;

endmodule
`default_nettype wire

// File: doc/result_display.md
RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 Parameter: REFRESH_DIV, default 1000, clock cycles per displayed digit (legal range >= 2).
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  new adder result present this cycle.
REQ-005 Port: in_sub  input  1  mode of the captured result: 0 = add, 1 = subtract (A + ~B + 1).
REQ-006 Port: in_ca  input  1  carry-out of the 4-bit adder.
REQ-007 Port: in_s  input  4  adder sum s3..s0 (in_s[0] = s0).
REQ-008 Port: out_ready  output  1  high when in_valid will be accepted.
REQ-009 Port: out_done  output  1  one-cycle pulse when new digits are latched.
REQ-010 Port: out_seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-011 Port: out_an  output  3  active-low digit enables {sign,tens,units}.

Function
REQ-012 The block SHALL implement the FSM states IDLE and CONV; out_ready = 1 only in IDLE.
REQ-013 The block SHALL accept a result on any edge where in_valid = 1 and state = IDLE, and SHALL move to CONV.
REQ-014 Value formation at accept: add mode -> magnitude = {in_ca, in_s} (0..31), sign positive.
REQ-015 Value formation at accept: sub mode with in_ca = 1 -> magnitude = in_s, sign positive.
REQ-016 Value formation at accept: sub mode with in_ca = 0 -> magnitude = 16 - in_s (1..15), sign negative.
REQ-017 CONV SHALL perform a 5-step shift-add-3 binary-to-BCD conversion, one step per edge, on the 5 edges following the accept edge.
REQ-018 On the 5th step edge the block SHALL latch units (0..9), tens (0..3) and sign into display registers, return to IDLE, and drive out_done = 1 for exactly that following cycle.
REQ-019 Latency: accept edge T0, digits visible after edge T5; a new result MAY be accepted at edge T6 (the out_done cycle).
REQ-020 in_valid while in CONV SHALL be ignored; no queuing; the in-flight conversion is unaffected.
REQ-021 The display registers SHALL hold the previous result throughout CONV (no partial digits shown).
REQ-022 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; on wrap the digit select SHALL advance units -> tens -> sign -> units.
REQ-023 Exactly one out_an bit SHALL be low at any time: units 3'b110, tens 3'b101, sign 3'b011.
REQ-024 Digit encoding (active-low): 0..9 standard seven-segment patterns (e.g. 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000).
REQ-025 Special encodings: minus = 7'b0111111; blank = 7'b1111111.
REQ-026 The tens digit SHALL be blank when tens = 0; the sign digit SHALL show minus when negative, otherwise blank.
REQ-027 The out_seg and out_an outputs SHALL be registered, changing only on clock edges.

Reset
REQ-028 On rst = 1 at an edge: state = IDLE; out_ready = 1; out_done = 0.
REQ-029 On rst = 1 at an edge: units = 0, tens = 0, sign positive.
REQ-030 On rst = 1 at an edge: refresh counter = 0; digit select = units; out_an = 3'b110; out_seg = 7'b1000000.
REQ-031 rst SHALL take priority over in_valid; rst during CONV SHALL abort the conversion, with no out_done pulse.

Verification
REQ-032 Add, in_ca=1, in_s=4'b0010 (9+9=18) -> after T5: units 8 (7'b0000000), tens 1 (7'b1111001), sign blank, out_done pulse at T6 only.
REQ-033 Sub, in_ca=0, in_s=4'b1110 (3-5) -> units 2 (7'b0100100), tens blank, sign 7'b0111111.
REQ-034 Add, in_ca=1, in_s=4'b1111 (31) -> units 1, tens 3 (7'b0110000); sub, in_ca=1, in_s=4'b0000 (5-5) -> units 0, tens and sign blank.
REQ-035 Handshake: in_valid held high for 10 cycles with two different values -> first accepted at T0, second at T6, out_ready low T1..T5.
REQ-036 rst asserted at T3 of a conversion -> next cycle out_ready=1, no out_done, display shows 0 with blanks.
REQ-037 REFRESH_DIV=4, no input -> out_an sequence 110 (4 cycles), 101 (4), 011 (4), 110, repeating.
